// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Entry widths track the default PC/instruction widths of the core.
package fetch_pkg;

  localparam int FP_PC_W = 32;
  localparam int FP_BITS = 32;

  localparam logic [FP_BITS-1:0] INSTR_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_IDLE,
    FS_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [FP_PC_W-1:0] pc;
    logic [FP_BITS-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Flush empties it and drops any same-cycle push.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, fills the fetch FIFO from
// InstMemory and feeds decode; handles redirects and faults.
import fetch_pkg::*;

module fetch_sequencer #(
  parameter int          DEPTH      = 32,
  parameter int          BITS       = 32,
  parameter int          PC_W       = 32,
  parameter int unsigned RESET_PC   = 0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [BITS-1:0] imem_rdata,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [BITS-1:0] if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            fault,
  output logic [PC_W-1:0] fault_pc
);

  localparam logic [PC_W:0] PC_LIMIT =
    (PC_W+1)'(DEPTH * 4);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [PC_W-1:0] pc;
  logic            pc_ok;
  logic            push;
  logic            pop;
  logic            fault_set;
  logic            full;
  logic            empty;
  fetch_entry_t    entry_in;
  fetch_entry_t    head;

  assign pc_ok = ({1'b0, pc} < PC_LIMIT)
               && (pc[1:0] == 2'b00);

  assign pop  = if_valid & if_ready;
  assign push = (state == FS_RUN) & fetch_en
              & pc_ok & (~full | pop);

  assign entry_in.pc    = pc;
  assign entry_in.instr = imem_rdata;

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redir_valid),
    .wdata(entry_in),
    .full (full),
    .empty(empty),
    .head (head)
  );

  // Head registers only; nothing from imem_rdata reaches decode.
  assign imem_addr = pc;
  assign if_valid  = ~empty;
  assign if_instr  = empty ? INSTR_NOP : head.instr;
  assign if_pc     = empty ? '0 : head.pc;

  always_comb begin
    state_nxt = state;
    fault_set = 1'b0;
    unique case (state)
      FS_RUN: begin
        if (!fetch_en) begin
          state_nxt = FS_IDLE;
        end else if (!pc_ok) begin
          state_nxt = FS_FAULT;
          fault_set = 1'b1;
        end
      end
      FS_IDLE: begin
        if (fetch_en)
          state_nxt = FS_RUN;
      end
      FS_FAULT: begin
        state_nxt = FS_FAULT;
      end
      default: begin
        state_nxt = FS_RUN;
      end
    endcase
    if (redir_valid) begin
      state_nxt = fetch_en ? FS_RUN : FS_IDLE;
      fault_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FS_RUN;
      pc       <= PC_W'(RESET_PC);
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state <= state_nxt;
      if (redir_valid) begin
        pc       <= redir_pc;
        fault    <= 1'b0;
        fault_pc <= '0;
      end else begin
        if (push)
          pc <= pc + PC_W'(4);
        if (fault_set) begin
          fault    <= 1'b1;
          fault_pc <= pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus random traffic against a
// queue-based fetch model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int M_RUN   = 0;
  localparam int M_IDLE  = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [32];

  int total = 0;
  int bad   = 0;

  logic [31:0] mpc;
  int          mmode;
  logic        mfault;
  logic [31:0] mfpc;
  logic [63:0] mq[$];

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd128)
                    ? mem[imem_addr[6:2]]
                    : 32'hDEADBEEF;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .fault      (fault),
    .fault_pc   (fault_pc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  function automatic bit pc_bad(logic [31:0] p);
    return (p >= 32'd128) || (p % 4 != 0);
  endfunction

  // Advance the model across one clock edge.
  task automatic model_edge();
    bit pop;
    pop = (mq.size() > 0) && if_ready;
    if (!rst) begin
      mq.delete();
      mpc    = 32'd0;
      mmode  = M_RUN;
      mfault = 1'b0;
      mfpc   = 32'd0;
    end else if (redir_valid) begin
      mq.delete();
      mpc    = redir_pc;
      mmode  = fetch_en ? M_RUN : M_IDLE;
      mfault = 1'b0;
      mfpc   = 32'd0;
    end else begin
      if (pop)
        void'(mq.pop_front());
      if (mmode == M_RUN) begin
        if (!fetch_en) begin
          mmode = M_IDLE;
        end else if (pc_bad(mpc)) begin
          mmode  = M_FAULT;
          mfault = 1'b1;
          mfpc   = mpc;
        end else if (mq.size() < 2) begin
          mq.push_back({mpc, mem[mpc / 4]});
          mpc = mpc + 32'd4;
        end
      end else if (mmode == M_IDLE) begin
        if (fetch_en)
          mmode = M_RUN;
      end
    end
  endtask

  task automatic step(input bit do_chk = 1'b1);
    @(negedge clk);
    if (do_chk) begin
      chk("imem_addr", imem_addr, mpc);
      chk("if_valid", 32'(if_valid),
          32'(mq.size() > 0));
      chk("if_pc", if_pc,
          mq.size() > 0 ? mq[0][63:32] : 32'd0);
      chk("if_instr", if_instr,
          mq.size() > 0 ? mq[0][31:0] : NOP);
      chk("fault", 32'(fault), 32'(mfault));
      chk("fault_pc", fault_pc, mfpc);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++)
      step();
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid = 1'b1;
    redir_pc    = t;
    step();
    redir_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      mem[i] = 32'(i);
    rst         = 1'b0;
    fetch_en    = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = '0;
    if_ready    = 1'b1;
    step(1'b0);
    step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // streaming, one word per cycle
    rst = 1'b1;
    step();
    chk("s1_first_pc", if_pc, 32'd0);
    chk("s1_first_v", 32'(if_valid), 32'd1);
    steps(6);

    // back-pressure from a fresh reset
    rst = 1'b0;
    step();
    rst      = 1'b1;
    if_ready = 1'b0;
    steps(5);
    chk("bp_addr", imem_addr, 32'd8);
    chk("bp_head", if_pc, 32'd0);
    if_ready = 1'b1;
    steps(4);

    // redirect while 0,4 are buffered
    rst = 1'b0;
    step();
    rst      = 1'b1;
    if_ready = 1'b0;
    steps(3);
    redirect(32'd20);
    chk("rd_empty", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    step();
    chk("rd_pc20", if_pc, 32'd20);
    steps(3);

    // run off the end of memory
    steps(40);
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_fpc", fault_pc, 32'd128);
    redirect(32'd0);
    chk("end_clr", 32'(fault), 32'd0);
    steps(3);

    // misaligned redirect target
    redirect(32'd6);
    steps(3);
    chk("mis_fpc", fault_pc, 32'd6);
    chk("mis_v", 32'(if_valid), 32'd0);

    // reset with full FIFO and fault pending
    if_ready = 1'b0;
    redirect(32'd120);
    steps(4);
    chk("pre_fault", 32'(fault), 32'd1);
    chk("pre_full", if_pc, 32'd120);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("r6_addr", imem_addr, 32'd0);
    chk("r6_v", 32'(if_valid), 32'd0);
    chk("r6_fault", 32'(fault), 32'd0);
    steps(2);
    if_ready = 1'b1;
    redirect(32'd40);
    steps(3);

    // fetch_en drop mid-stream
    fetch_en = 1'b0;
    steps(4);
    fetch_en = 1'b1;
    steps(3);

    // random traffic
    for (int i = 0; i < 32; i++)
      mem[i] = $urandom;
    for (int c = 0; c < 600; c++) begin
      int r;
      fetch_en    = ($urandom_range(0, 9) != 0);
      if_ready    = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 99) != 0);
      redir_valid = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)
        redir_pc = $urandom_range(0, 200);
      else
        redir_pc = 32'($urandom_range(0, 31)) * 4;
      step();
    end
    rst         = 1'b1;
    redir_valid = 1'b0;
    steps(2);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
